// File: rtl/imem_port_arb.sv
// Instruction-memory BRAM port arbiter: the loader has fixed priority over CPU fetch, with a
// read-tag pipeline and a CPU hold FSM. Define IMEM_ARB_STATS_EN to add the write/conflict counters.
module imem_port_arb #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int BRAM_LAT = 1
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                ld_req_valid,
  input  logic                ld_req_we,
  input  logic [31:0]         ld_req_addr,
  input  logic [DATA_W-1:0]   ld_req_wdata,
  input  logic [DATA_W/8-1:0] ld_req_wstrb,
  output logic                ld_rsp_valid,
  output logic [DATA_W-1:0]   ld_rsp_rdata,
  output logic                ld_rsp_err,
  input  logic                ld_start,
  input  logic                ld_done,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_stall,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                cpu_hold,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  input  logic [DATA_W-1:0]   bram_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]         stat_wr_cnt,
  output logic [15:0]         stat_conflict_cnt
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int TAIL   = BRAM_LAT - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic                hold_r;

  logic                ld_oor_s;
  logic                if_issue_s;
  logic                rd_issue_s;
  logic                rd_owner_ld_s;
  logic                rd_oor_s;

  logic                bram_en_s;
  logic [STRB_W-1:0]   bram_we_s;
  logic [ADDR_W-1:0]   bram_addr_s;
  logic [DATA_W-1:0]   bram_wdata_s;

  logic [BRAM_LAT-1:0] tag_v_r;
  logic [BRAM_LAT-1:0] tag_own_r;
  logic [BRAM_LAT-1:0] tag_oor_r;

  logic                ld_rsp_valid_r;
  logic                ld_rsp_err_r;
  logic [DATA_W-1:0]   ld_rsp_rdata_r;
  logic                if_rvalid_r;
  logic [DATA_W-1:0]   if_rdata_r;

  // Byte-offset bits of the loader address carry no meaning for a word-wide BRAM.
  logic                unused_s;
  assign unused_s = ^ld_req_addr[1:0];

  assign ld_oor_s      = |ld_req_addr[31:ADDR_W+2];
  assign if_issue_s    = if_req && !ld_req_valid && !hold_r;
  assign rd_issue_s    = (ld_req_valid && !ld_req_we) || if_issue_s;
  assign rd_owner_ld_s = ld_req_valid;
  assign rd_oor_s      = ld_req_valid && ld_oor_s;

  // Port mux: loader first, then fetch; out-of-range loader accesses never touch the BRAM.
  always_comb begin
    bram_en_s    = 1'b0;
    bram_we_s    = {STRB_W{1'b0}};
    bram_addr_s  = if_addr;
    bram_wdata_s = ld_req_wdata;
    if (!ARESETN) begin
      bram_en_s = 1'b0;
    end else if (ld_req_valid) begin
      bram_addr_s = ld_req_addr[ADDR_W+1:2];
      if (ld_oor_s) begin
        bram_en_s = 1'b0;
      end else begin
        bram_en_s = 1'b1;
        if (ld_req_we) begin
          bram_we_s = ld_req_wstrb;
        end else begin
          bram_we_s = {STRB_W{1'b0}};
        end
      end
    end else if (if_issue_s) begin
      bram_en_s = 1'b1;
    end else begin
      bram_en_s = 1'b0;
    end
  end

  assign bram_en    = bram_en_s;
  assign bram_we    = bram_we_s;
  assign bram_addr  = bram_addr_s;
  assign bram_wdata = bram_wdata_s;
  assign if_stall   = if_req && (ld_req_valid || hold_r);

  // Read-tag shift register, one stage per cycle of BRAM read latency.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tag_v_r   <= {BRAM_LAT{1'b0}};
      tag_own_r <= {BRAM_LAT{1'b0}};
      tag_oor_r <= {BRAM_LAT{1'b0}};
    end else begin
      tag_v_r[0]   <= rd_issue_s;
      tag_own_r[0] <= rd_owner_ld_s;
      tag_oor_r[0] <= rd_oor_s;
      for (int i = 1; i < BRAM_LAT; i++) begin
        tag_v_r[i]   <= tag_v_r[i-1];
        tag_own_r[i] <= tag_own_r[i-1];
        tag_oor_r[i] <= tag_oor_r[i-1];
      end
    end
  end

  // Response registers: route the returning word to its owner; rdata holds between pulses.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ld_rsp_valid_r <= 1'b0;
      ld_rsp_err_r   <= 1'b0;
      ld_rsp_rdata_r <= {DATA_W{1'b0}};
      if_rvalid_r    <= 1'b0;
      if_rdata_r     <= {DATA_W{1'b0}};
    end else begin
      ld_rsp_valid_r <= tag_v_r[TAIL] && tag_own_r[TAIL];
      ld_rsp_err_r   <= tag_v_r[TAIL] && tag_own_r[TAIL] && tag_oor_r[TAIL];
      if_rvalid_r    <= tag_v_r[TAIL] && !tag_own_r[TAIL];
      if (tag_v_r[TAIL] && tag_own_r[TAIL]) begin
        ld_rsp_rdata_r <= tag_oor_r[TAIL] ? {DATA_W{1'b0}} : bram_rdata;
      end
      if (tag_v_r[TAIL] && !tag_own_r[TAIL]) begin
        if_rdata_r <= bram_rdata;
      end
    end
  end

  assign ld_rsp_valid = ld_rsp_valid_r;
  assign ld_rsp_err   = ld_rsp_err_r;
  assign ld_rsp_rdata = ld_rsp_rdata_r;
  assign if_rvalid    = if_rvalid_r;
  assign if_rdata     = if_rdata_r;

  // Hold FSM next state; ld_start has precedence over ld_done while running.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (ld_start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (ld_done) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!(|tag_v_r)) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // Hold FSM state and its registered hold output.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r <= ST_RUN;
      hold_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      hold_r  <= (state_next_s != ST_RUN);
    end
  end

  assign cpu_hold = hold_r;

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] wr_cnt_r;
  logic [15:0] conflict_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Saturating statistics; a new program load restarts both counts.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_cnt_r       <= 16'd0;
      conflict_cnt_r <= 16'd0;
    end else if (ld_start) begin
      wr_cnt_r       <= 16'd0;
      conflict_cnt_r <= 16'd0;
    end else begin
      if (ld_req_valid && ld_req_we && !ld_oor_s && (|ld_req_wstrb)) begin
        wr_cnt_r <= sat_inc(wr_cnt_r);
      end
      if (if_req && ld_req_valid) begin
        conflict_cnt_r <= sat_inc(conflict_cnt_r);
      end
    end
  end

  assign stat_wr_cnt       = wr_cnt_r;
  assign stat_conflict_cnt = conflict_cnt_r;
`endif

endmodule
